// File: rtl/dm_pkg.sv
// dm_pkg: shared encodings for the data-memory load/store path.
//   - store size encodings (SZ_*), load type encodings (LD_LB..LD_LW)
//   - load-unit FSM state encoding
//   - default bus timeout for dm_load_unit
//   - helpers: load type legality, access size, alignment
// Optional feature macro used by dm_load_unit: DM_ALIGN_CHECK_EN.
package dm_pkg;

    // Store byte-enable size encoding; loads map onto the same sizes.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Load type encoding as driven by the MEM stage.
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;
    localparam logic [2:0] LD_LW  = 3'd5;

    localparam int unsigned DM_TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } dm_ld_state_e;

    function automatic logic ld_type_legal(input logic [2:0] ld_type);
        return (ld_type >= LD_LB) && (ld_type <= LD_LW);
    endfunction

    function automatic logic [1:0] ld_size(input logic [2:0] ld_type);
        logic [1:0] sz;
        unique case (ld_type)
            LD_LB, LD_LBU: sz = SZ_BYTE;
            LD_LH, LD_LHU: sz = SZ_HALF;
            default:       sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic ld_misaligned(input logic [2:0] ld_type, input logic [1:0] addr);
        logic mis;
        unique case (ld_size(ld_type))
            SZ_HALF: mis = addr[0];
            SZ_WORD: mis = |addr;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dm_load_unit_if.sv
// dm_load_unit_if: request, data-memory read and response signals of the load unit.
//   slave  : the load unit's view (takes requests, drives the memory read, returns results)
//   master : the surrounding pipeline/memory view
interface dm_load_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_type;
    logic        mem_rd_en;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    modport slave (
        input  req_valid, req_addr, req_type, mem_rdata, mem_ack, rsp_ready,
        output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_err, busy
    );

    modport master (
        output req_valid, req_addr, req_type, mem_rdata, mem_ack, rsp_ready,
        input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/dm_load_ext.sv
// dm_load_ext: combinational lane select and sign/zero extension of a read word.
//   rdata   in  32  word returned by data memory
//   addr    in  2   byte offset within the word
//   ld_type in  3   load type (LD_LB..LD_LW); illegal types yield 0
//   data    out 32  extended load result
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  ld_type,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = 8'h00;
        unique case (addr)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
            default: byte_lane = 8'h00;
        endcase
        // Halfword ignores addr[0]; misalignment is screened before the read.
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

        data = '0;
        case (ld_type)
            LD_LB:   data = {{24{byte_lane[7]}}, byte_lane};
            LD_LBU:  data = {24'h000000, byte_lane};
            LD_LH:   data = {{16{half_lane[15]}}, half_lane};
            LD_LHU:  data = {16'h0000, half_lane};
            LD_LW:   data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/dm_load_unit.sv
// dm_load_unit: load-return path of the data memory.
// Accepts a load request, issues a word read, waits for mem_ack (bounded by TIMEOUT),
// extracts/extends the addressed lane and holds the result until rsp_ready.
//   TIMEOUT  param  max WAIT cycles without mem_ack before a bus error (2..255)
//   clk      in     system clock, rising edge
//   reset    in     synchronous, active-high
//   bus      slave  dm_load_unit_if: req_*, mem_*, rsp_*, busy
// Macro DM_ALIGN_CHECK_EN: when defined, misaligned lh/lhu/lw report rsp_err with no read.
module dm_load_unit
    import dm_pkg::*;
#(
    parameter int unsigned TIMEOUT = DM_TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    dm_load_unit_if.slave bus
);

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    dm_ld_state_e state_q;
    logic         rd_en_q;
    logic [29:0]  addr_q;
    logic [1:0]   lo_q;
    logic [2:0]   type_q;
    logic [7:0]   cnt_q;
    logic         rsp_valid_q;
    logic [31:0]  rsp_data_q;
    logic         rsp_err_q;

    logic         misaligned;
    logic         req_bad;
    logic [31:0]  ext_data;

`ifdef DM_ALIGN_CHECK_EN
    assign misaligned = ld_misaligned(bus.req_type, bus.req_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign req_bad = !ld_type_legal(bus.req_type) || misaligned;

    dm_load_ext u_ext (
        .rdata   (bus.mem_rdata),
        .addr    (lo_q),
        .ld_type (type_q),
        .data    (ext_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            lo_q        <= '0;
            type_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        addr_q <= bus.req_addr[31:2];
                        lo_q   <= bus.req_addr[1:0];
                        type_q <= bus.req_type;
                        cnt_q  <= '0;
                        if (req_bad) begin
                            // Rejected without touching memory.
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state_q <= StWait;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                StWait: begin
                    // Ack takes priority over a coincident timeout.
                    if (bus.mem_ack) begin
                        state_q     <= StResp;
                        rd_en_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= ext_data;
                        rsp_err_q   <= 1'b0;
                    end else if (cnt_q == CntLast) begin
                        state_q     <= StResp;
                        rd_en_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    rd_en_q     <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.mem_rd_en = rd_en_q;
    assign bus.mem_addr  = addr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dm_load_unit.sv
// tb_dm_load_unit: table-driven directed bench for dm_load_unit (TIMEOUT = 4),
// plus hand-written reset-abort sequence. Expectations follow DM_ALIGN_CHECK_EN.
module tb_dm_load_unit;
    import dm_pkg::*;

    logic clk;
    logic reset;

    dm_load_unit_if bus ();

    dm_load_unit #(
        .TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  typ;
        int          ack;   // cycle after acceptance carrying mem_ack, 0 = never
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic        exp_err;
        int          lat;   // cycle after acceptance in which rsp_valid first rises
        int          hold;  // cycles rsp_ready stays low once valid
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [0:NV-1];

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] D0 = 32'h80FF7F01;
    localparam logic [31:0] D1 = 32'h87654321;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic [2:0] typ, input int ack,
                                input logic [31:0] rdata, input logic [31:0] exp_data,
                                input logic exp_err, input int lat, input int hold);
        vec_t v;
        v.addr = addr; v.typ = typ; v.ack = ack; v.rdata = rdata;
        v.exp_data = exp_data; v.exp_err = exp_err; v.lat = lat; v.hold = hold;
        return v;
    endfunction

    // Called at a negedge with the unit idle; returns at a negedge with the unit idle.
    task automatic run_vec(input vec_t v, input int idx);
        logic        got;
        logic        rd_ok;
        logic        hold_ok;
        logic        exp_rd;
        logic [31:0] d0;
        logic        e0;
        int          lat_seen;

        got = 1'b0; rd_ok = 1'b1; hold_ok = 1'b1;
        d0 = '0; e0 = 1'b0; lat_seen = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = v.addr;
        bus.req_type  = v.typ;
        bus.mem_rdata = v.rdata;
        bus.mem_ack   = 1'b0;
        bus.rsp_ready = (v.hold == 0);
        check($sformatf("v%0d req_ready", idx), 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            exp_rd = (k < v.lat);
            if (bus.mem_rd_en !== exp_rd || (exp_rd && bus.mem_addr !== v.addr[31:2]) ||
                bus.busy !== 1'b1 || bus.req_ready !== 1'b0)
                rd_ok = 1'b0;
            if (bus.rsp_valid === 1'b1) begin
                got = 1'b1; lat_seen = k; d0 = bus.rsp_data; e0 = bus.rsp_err;
                break;
            end
            bus.mem_ack = (k == v.ack);
        end
        bus.mem_ack = 1'b0;
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL v%0d rsp_valid: never seen within 40 cycles, expected cycle %0d",
                     idx, v.lat);
            bus.rsp_ready = 1'b1;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            return;
        end
        check($sformatf("v%0d latency", idx), 32'(lat_seen), 32'(v.lat));
        check($sformatf("v%0d rsp_data", idx), d0, v.exp_data);
        check($sformatf("v%0d rsp_err", idx), 32'(e0), 32'(v.exp_err));
        check($sformatf("v%0d mem_rd_en/mem_addr/busy", idx), 32'(rd_ok), 32'd1);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d0 || bus.rsp_err !== e0 ||
                bus.req_ready !== 1'b0)
                hold_ok = 1'b0;
        end
        if (v.hold > 0) check($sformatf("v%0d hold stable", idx), 32'(hold_ok), 32'd1);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check($sformatf("v%0d turnaround", idx),
              {30'd0, bus.req_ready, bus.rsp_valid}, 32'b10);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(32'h3,    LD_LB,  1, D0, 32'hFFFFFF80, 1'b0, 2, 0);
        vecs[1]  = mk(32'h1,    LD_LBU, 1, D0, 32'h0000007F, 1'b0, 2, 0);
        vecs[2]  = mk(32'h2,    LD_LB,  1, D0, 32'hFFFFFFFF, 1'b0, 2, 0);
        vecs[3]  = mk(32'h2,    LD_LH,  1, D0, 32'hFFFF80FF, 1'b0, 2, 0);
        vecs[4]  = mk(32'h0,    LD_LHU, 1, D0, 32'h00007F01, 1'b0, 2, 0);
        vecs[5]  = mk(32'h1004, LD_LW,  4, D0, 32'h80FF7F01, 1'b0, 5, 4);
`ifdef DM_ALIGN_CHECK_EN
        vecs[6]  = mk(32'h1,    LD_LH,  1, D0, 32'h00000000, 1'b1, 1, 0);
        vecs[13] = mk(32'h3,    LD_LW,  1, D0, 32'h00000000, 1'b1, 1, 0);
`else
        vecs[6]  = mk(32'h1,    LD_LH,  1, D0, 32'h00007F01, 1'b0, 2, 0);
        vecs[13] = mk(32'h3,    LD_LW,  1, D0, 32'h80FF7F01, 1'b0, 2, 0);
`endif
        vecs[7]  = mk(32'h0,    LD_LW,  0, D0, 32'h00000000, 1'b1, 5, 0);
        vecs[8]  = mk(32'h0,    LD_LW,  4, D0, 32'h80FF7F01, 1'b0, 5, 0);
        vecs[9]  = mk(32'h3,    LD_LBU, 2, D0, 32'h00000080, 1'b0, 3, 0);
        vecs[10] = mk(32'h2,    LD_LH,  1, D1, 32'hFFFF8765, 1'b0, 2, 0);
        vecs[11] = mk(32'h0,    3'd0,   1, D1, 32'h00000000, 1'b1, 1, 0);
        vecs[12] = mk(32'h2,    LD_LHU, 3, D1, 32'h00008765, 1'b0, 4, 2);
        vecs[14] = mk(32'h5,    3'd7,   1, D1, 32'h00000000, 1'b1, 1, 0);

        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_type = '0;
        bus.mem_rdata = '0; bus.mem_ack = 1'b0; bus.rsp_ready = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset req_ready", 32'(bus.req_ready), 32'd1);
        check("reset mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
        check("reset mem_addr", 32'(bus.mem_addr), 32'd0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset rsp_data", bus.rsp_data, 32'd0);
        check("reset rsp_err", 32'(bus.rsp_err), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);

        for (int i = 0; i < NV - 1; i++) run_vec(vecs[i], i);

        // Reset during the second WAIT cycle, then a stray ack while idle.
        bus.req_valid = 1'b1; bus.req_addr = 32'h40; bus.req_type = LD_LW;
        bus.mem_rdata = D0; bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("abort wait1 mem_rd_en", 32'(bus.mem_rd_en), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
        check("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort req_ready", 32'(bus.req_ready), 32'd1);
        reset = 1'b0;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("late ack rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("late ack busy", 32'(bus.busy), 32'd0);
        run_vec(vecs[NV-1], NV - 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
